// File: rtl/bbox_pkg.sv
// Shared constants, FSM state type and message word packing for the bbox tracker.
package bbox_pkg;

    localparam logic [31:0] MSG_HDR = 32'hAAAA_AAAA;
    localparam logic [15:0] TRL_TAG = 16'hBBBB;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        CH,
        TRL
    } msg_state_t;

    // An invalid channel reports an empty box so the CPU never sees stale coordinates.
    function automatic logic [31:0] pack_ch_word(
        input logic        valid,
        input logic [14:0] x_min,
        input logic [15:0] x_max
    );
        return valid ? {1'b1, x_min, x_max} : 32'h0;
    endfunction

endpackage

// File: rtl/bbox_accum.sv
// Per-channel bounding-box accumulator: running x/y min/max and a saturating hit count.
module bbox_accum #(
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init_i,
    input  logic          upd_i,
    input  logic [CW-1:0] x_i,
    input  logic [CW-1:0] y_i,
    output logic [CW-1:0] x_min_o,
    output logic [CW-1:0] x_max_o,
    output logic [CW-1:0] y_min_o,
    output logic [CW-1:0] y_max_o,
    output logic [15:0]   count_o
);

    logic [CW-1:0] x_min_q, x_min_d;
    logic [CW-1:0] x_max_q, x_max_d;
    logic [CW-1:0] y_min_q, y_min_d;
    logic [CW-1:0] y_max_q, y_max_d;
    logic [15:0]   count_q, count_d;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latch).
        x_min_d = x_min_q;
        x_max_d = x_max_q;
        y_min_d = y_min_q;
        y_max_d = y_max_q;
        count_d = count_q;
        if (init_i) begin
            x_min_d = '1;
            x_max_d = '0;
            y_min_d = '1;
            y_max_d = '0;
            count_d = '0;
        end else if (upd_i) begin
            if (x_i < x_min_q) x_min_d = x_i;
            if (x_i > x_max_q) x_max_d = x_i;
            if (y_i < y_min_q) y_min_d = y_i;
            if (y_i > y_max_q) y_max_d = y_i;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (reset) begin
            x_min_q <= '1;
            x_max_q <= '0;
            y_min_q <= '1;
            y_max_q <= '0;
            count_q <= '0;
        end else begin
            x_min_q <= x_min_d;
            x_max_q <= x_max_d;
            y_min_q <= y_min_d;
            y_max_q <= y_max_d;
            count_q <= count_d;
        end
    end

    assign x_min_o = x_min_q;
    assign x_max_o = x_max_q;
    assign y_min_o = y_min_q;
    assign y_max_o = y_max_q;
    assign count_o = count_q;

endmodule

// File: rtl/bbox_tracker.sv
// N-channel colour bounding-box tracker with ROI, validity threshold and a frame-paced
// message writer that emits header, one word per channel and a sequence trailer.
module bbox_tracker
    import bbox_pkg::*;
#(
    parameter int N_CH       = 6,
    parameter int CW         = 11,
    parameter int FIFO_DEPTH = 256,
    parameter int FIFO_AW    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic               pix_sop,
    input  logic               pix_eop,
    input  logic               pix_is_video,
    input  logic [CW-1:0]      pix_x,
    input  logic [CW-1:0]      pix_y,
    input  logic [N_CH-1:0]    pix_hit,
    input  logic [CW-1:0]      roi_left,
    input  logic [CW-1:0]      roi_right,
    input  logic [CW-1:0]      roi_top,
    input  logic [CW-1:0]      roi_bottom,
    input  logic [15:0]        min_pixels,
    input  logic [7:0]         msg_interval,
    input  logic [FIFO_AW:0]   fifo_usedw,
    output logic [31:0]        msg_data,
    output logic               msg_wr,
    output logic [N_CH*CW-1:0] box_left,
    output logic [N_CH*CW-1:0] box_right,
    output logic [N_CH*CW-1:0] box_top,
    output logic [N_CH*CW-1:0] box_bottom,
    output logic [N_CH-1:0]    box_valid,
    output logic               frame_done,
    output logic               busy
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
    // A message is only started when the whole burst is guaranteed to fit.
    localparam logic [FIFO_AW:0] USEDW_LIMIT = (FIFO_AW + 1)'(FIFO_DEPTH - (N_CH + 2));

    logic            in_roi;
    logic            acc_init;
    logic            acc_take;
    logic            video_eop;
    logic [N_CH-1:0] hit_sel;
    logic [N_CH-1:0] valid_now;

    logic [CW-1:0] acc_xmin  [N_CH];
    logic [CW-1:0] acc_xmax  [N_CH];
    logic [CW-1:0] acc_ymin  [N_CH];
    logic [CW-1:0] acc_ymax  [N_CH];
    logic [15:0]   acc_count [N_CH];

    assign in_roi    = (pix_x >= roi_left) && (pix_x <= roi_right) &&
                       (pix_y >= roi_top)  && (pix_y <= roi_bottom);
    assign acc_init  = pix_valid & pix_sop;
    assign acc_take  = pix_valid & ~pix_sop & in_roi;
    assign video_eop = pix_valid & pix_eop & pix_is_video;

    always_comb begin
        hit_sel = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pix_hit[i]) begin
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_acc
        bbox_accum #(.CW(CW)) u_accum (
            .clk     (clk),
            .reset   (reset),
            .init_i  (acc_init),
            .upd_i   (acc_take & hit_sel[g]),
            .x_i     (pix_x),
            .y_i     (pix_y),
            .x_min_o (acc_xmin[g]),
            .x_max_o (acc_xmax[g]),
            .y_min_o (acc_ymin[g]),
            .y_max_o (acc_ymax[g]),
            .count_o (acc_count[g])
        );
        assign valid_now[g] = (acc_count[g] >= min_pixels);
    end

    // Overlay boxes: latched from pre-edge accumulators, so the eop pixel never contributes.
    logic [N_CH*CW-1:0] box_left_q, box_right_q, box_top_q, box_bottom_q;
    logic [N_CH-1:0]    box_valid_q;
    logic               frame_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            box_left_q   <= '0;
            box_right_q  <= '0;
            box_top_q    <= '0;
            box_bottom_q <= '0;
            box_valid_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= video_eop;
            if (video_eop) begin
                for (int i = 0; i < N_CH; i++) begin
                    box_left_q[i*CW +: CW]   <= acc_xmin[i];
                    box_right_q[i*CW +: CW]  <= acc_xmax[i];
                    box_top_q[i*CW +: CW]    <= acc_ymin[i];
                    box_bottom_q[i*CW +: CW] <= acc_ymax[i];
                end
                box_valid_q <= valid_now;
            end
        end
    end

    msg_state_t       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] nxt_idx;
    logic [31:0]      msg_data_q;
    logic             msg_wr_q;
    logic             busy_q;
    logic [7:0]       frm_cnt_q;
    logic [7:0]       frm_reload;
    logic [15:0]      seq_q;
    logic             start_ok;
    logic             msg_start;

    logic [N_CH-1:0] snap_valid_q;
    logic [CW-1:0]   snap_xmin_q [N_CH];
    logic [CW-1:0]   snap_xmax_q [N_CH];
    logic [15:0]     snap_seq_q;
    logic [31:0]     ch_words    [N_CH];

    assign nxt_idx    = idx_q + IDX_W'(1);
    assign frm_reload = (msg_interval == 8'd0) ? 8'd0 : msg_interval - 8'd1;
    assign start_ok   = (frm_cnt_q == 8'd0) && (state_q == IDLE) && (fifo_usedw <= USEDW_LIMIT);
    assign msg_start  = video_eop & start_ok;

    // NOTE: snapshot registers carry no reset; they are always written on msg_start before the FSM reads them.
    always_ff @(posedge clk) begin
        if (msg_start) begin
            snap_valid_q <= valid_now;
            snap_seq_q   <= seq_q;
            for (int i = 0; i < N_CH; i++) begin
                snap_xmin_q[i] <= acc_xmin[i];
                snap_xmax_q[i] <= acc_xmax[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ch_words[i] = pack_ch_word(snap_valid_q[i], 15'(snap_xmin_q[i]), 16'(snap_xmax_q[i]));
        end
    end

    // Each state names the word currently presented on msg_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            msg_data_q <= '0;
            msg_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
            frm_cnt_q  <= '0;
            seq_q      <= '0;
        end else begin
            if (video_eop) begin
                seq_q <= seq_q + 16'd1;
                if (start_ok)               frm_cnt_q <= frm_reload;
                else if (frm_cnt_q != 8'd0) frm_cnt_q <= frm_cnt_q - 8'd1;
            end
            case (state_q)
                IDLE: begin
                    if (msg_start) begin
                        state_q    <= HDR;
                        msg_data_q <= MSG_HDR;
                        msg_wr_q   <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                HDR: begin
                    state_q    <= CH;
                    idx_q      <= '0;
                    msg_data_q <= ch_words[0];
                end
                CH: begin
                    if (idx_q == LAST_IDX) begin
                        state_q    <= TRL;
                        msg_data_q <= {TRL_TAG, snap_seq_q};
                    end else begin
                        idx_q      <= nxt_idx;
                        msg_data_q <= ch_words[nxt_idx];
                    end
                end
                TRL: begin
                    state_q    <= IDLE;
                    msg_data_q <= '0;
                    msg_wr_q   <= 1'b0;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    msg_wr_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign msg_data   = msg_data_q;
    assign msg_wr     = msg_wr_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign box_left   = box_left_q;
    assign box_right  = box_right_q;
    assign box_top    = box_top_q;
    assign box_bottom = box_bottom_q;
    assign box_valid  = box_valid_q;

endmodule
